// File: rtl/decode_alu_ctrl.sv
// RV32I decode stage: turns a fetched instruction into a registered ALU/branch/writeback
// control bundle for execute, with valid/ready handshakes on both sides and a flush.
module decode_alu_ctrl #(
    parameter int unsigned alu_op_size = 4,
    parameter int unsigned xlen        = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [xlen-1:0]        instr,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [alu_op_size-1:0] alu_op,
    output logic [2:0]             branch,
    output logic [xlen-1:0]        imm,
    output logic [1:0]             op1_sel,
    output logic                   op2_sel,
    output logic [4:0]             rs1,
    output logic [4:0]             rs2,
    output logic [4:0]             rd,
    output logic                   reg_write,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic                   illegal
);

    // ALU operation codes shared with the execute-stage ALU
    localparam logic [alu_op_size-1:0] alu_and  = alu_op_size'(0);
    localparam logic [alu_op_size-1:0] alu_or   = alu_op_size'(1);
    localparam logic [alu_op_size-1:0] alu_xor  = alu_op_size'(2);
    localparam logic [alu_op_size-1:0] alu_add  = alu_op_size'(3);
    localparam logic [alu_op_size-1:0] alu_sub  = alu_op_size'(4);
    localparam logic [alu_op_size-1:0] alu_sll  = alu_op_size'(5);
    localparam logic [alu_op_size-1:0] alu_srl  = alu_op_size'(6);
    localparam logic [alu_op_size-1:0] alu_sltu = alu_op_size'(7);
    localparam logic [alu_op_size-1:0] alu_slt  = alu_op_size'(8);

    localparam logic [2:0] br_beq  = 3'd0;
    localparam logic [2:0] br_bne  = 3'd1;
    localparam logic [2:0] br_blt  = 3'd2;
    localparam logic [2:0] br_bge  = 3'd3;
    localparam logic [2:0] br_bltu = 3'd4;
    localparam logic [2:0] br_bgeu = 3'd5;
    localparam logic [2:0] br_jal  = 3'd6;
    localparam logic [2:0] br_none = 3'd7;

    localparam logic [6:0] opc_op     = 7'b0110011;
    localparam logic [6:0] opc_op_imm = 7'b0010011;
    localparam logic [6:0] opc_load   = 7'b0000011;
    localparam logic [6:0] opc_store  = 7'b0100011;
    localparam logic [6:0] opc_branch = 7'b1100011;
    localparam logic [6:0] opc_jal    = 7'b1101111;
    localparam logic [6:0] opc_jalr   = 7'b1100111;
    localparam logic [6:0] opc_lui    = 7'b0110111;
    localparam logic [6:0] opc_auipc  = 7'b0010111;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [xlen-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = {{(xlen-12){instr[31]}}, instr[31:20]};
    assign imm_s  = {{(xlen-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{(xlen-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {instr[31:12], 12'b0};
    assign imm_j  = {{(xlen-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_sh = xlen'(instr[24:20]);

    logic [alu_op_size-1:0] d_alu_op;
    logic [2:0]             d_branch;
    logic [xlen-1:0]        d_imm;
    logic [1:0]             d_op1_sel;
    logic                   d_op2_sel;
    logic [4:0]             d_rs1, d_rs2, d_rd;
    logic                   d_reg_write, d_mem_read, d_mem_write, d_illegal;

    // Combinational decode of the incoming instruction word
    always_comb begin
        d_alu_op    = alu_add;
        d_branch    = br_none;
        d_imm       = '0;
        d_op1_sel   = 2'd0;
        d_op2_sel   = 1'b0;
        d_rs1       = 5'd0;
        d_rs2       = 5'd0;
        d_rd        = 5'd0;
        d_reg_write = 1'b0;
        d_mem_read  = 1'b0;
        d_mem_write = 1'b0;
        d_illegal   = 1'b0;

        unique case (opcode)
            opc_op: begin
                d_rs1 = instr[19:15];
                d_rs2 = instr[24:20];
                d_rd  = instr[11:7];
                d_reg_write = 1'b1;
                case ({funct7, funct3})
                    10'b0000000_000: d_alu_op = alu_add;
                    10'b0100000_000: d_alu_op = alu_sub;
                    10'b0000000_001: d_alu_op = alu_sll;
                    10'b0000000_010: d_alu_op = alu_slt;
                    10'b0000000_011: d_alu_op = alu_sltu;
                    10'b0000000_100: d_alu_op = alu_xor;
                    10'b0000000_101: d_alu_op = alu_srl;
                    10'b0000000_110: d_alu_op = alu_or;
                    10'b0000000_111: d_alu_op = alu_and;
                    default:         d_illegal = 1'b1;
                endcase
            end
            opc_op_imm: begin
                d_rs1 = instr[19:15];
                d_rd  = instr[11:7];
                d_op2_sel = 1'b1;
                d_reg_write = 1'b1;
                d_imm = imm_i;
                case (funct3)
                    3'b000: d_alu_op = alu_add;
                    3'b010: d_alu_op = alu_slt;
                    3'b011: d_alu_op = alu_sltu;
                    3'b100: d_alu_op = alu_xor;
                    3'b110: d_alu_op = alu_or;
                    3'b111: d_alu_op = alu_and;
                    3'b001: begin
                        d_alu_op = alu_sll;
                        d_imm = imm_sh;
                        d_illegal = (funct7 != 7'b0);
                    end
                    default: begin
                        // SRAI has no ALU code, so only SRLI is accepted here
                        d_alu_op = alu_srl;
                        d_imm = imm_sh;
                        d_illegal = (funct7 != 7'b0);
                    end
                endcase
            end
            opc_load: begin
                d_rs1 = instr[19:15];
                d_rd  = instr[11:7];
                d_op2_sel = 1'b1;
                d_imm = imm_i;
                d_reg_write = 1'b1;
                d_mem_read = 1'b1;
            end
            opc_store: begin
                d_rs1 = instr[19:15];
                d_rs2 = instr[24:20];
                d_op2_sel = 1'b1;
                d_imm = imm_s;
                d_mem_write = 1'b1;
            end
            opc_branch: begin
                d_rs1 = instr[19:15];
                d_rs2 = instr[24:20];
                d_alu_op = alu_sub;
                d_imm = imm_b;
                case (funct3)
                    3'b000:  d_branch = br_beq;
                    3'b001:  d_branch = br_bne;
                    3'b100:  d_branch = br_blt;
                    3'b101:  d_branch = br_bge;
                    3'b110:  d_branch = br_bltu;
                    3'b111:  d_branch = br_bgeu;
                    default: d_illegal = 1'b1;
                endcase
            end
            opc_jal: begin
                d_rd = instr[11:7];
                d_op1_sel = 2'd1;
                d_op2_sel = 1'b1;
                d_imm = imm_j;
                d_branch = br_jal;
                d_reg_write = 1'b1;
            end
            opc_jalr: begin
                d_rs1 = instr[19:15];
                d_rd  = instr[11:7];
                d_op2_sel = 1'b1;
                d_imm = imm_i;
                d_branch = br_jal;
                d_reg_write = 1'b1;
                d_illegal = (funct3 != 3'b000);
            end
            opc_lui: begin
                d_rd = instr[11:7];
                d_op1_sel = 2'd2;
                d_op2_sel = 1'b1;
                d_imm = imm_u;
                d_reg_write = 1'b1;
            end
            opc_auipc: begin
                d_rd = instr[11:7];
                d_op1_sel = 2'd1;
                d_op2_sel = 1'b1;
                d_imm = imm_u;
                d_reg_write = 1'b1;
            end
            default: d_illegal = 1'b1;
        endcase

        // An illegal bundle carries no side effects, only the illegal flag
        if (d_illegal) begin
            d_alu_op    = alu_add;
            d_branch    = br_none;
            d_imm       = '0;
            d_op1_sel   = 2'd0;
            d_op2_sel   = 1'b0;
            d_rs1       = 5'd0;
            d_rs2       = 5'd0;
            d_rd        = 5'd0;
            d_reg_write = 1'b0;
            d_mem_read  = 1'b0;
            d_mem_write = 1'b0;
        end
        if (d_rd == 5'd0) d_reg_write = 1'b0;
    end

    logic capture;

    assign in_ready = !flush && (!out_valid || out_ready);
    assign capture  = in_valid && in_ready;

    // Pipeline register; data outputs only change on capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            alu_op    <= alu_add;
            branch    <= br_none;
            imm       <= '0;
            op1_sel   <= 2'd0;
            op2_sel   <= 1'b0;
            rs1       <= 5'd0;
            rs2       <= 5'd0;
            rd        <= 5'd0;
            reg_write <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            illegal   <= 1'b0;
        end else if (capture) begin
            out_valid <= 1'b1;
            alu_op    <= d_alu_op;
            branch    <= d_branch;
            imm       <= d_imm;
            op1_sel   <= d_op1_sel;
            op2_sel   <= d_op2_sel;
            rs1       <= d_rs1;
            rs2       <= d_rs2;
            rd        <= d_rd;
            reg_write <= d_reg_write;
            mem_read  <= d_mem_read;
            mem_write <= d_mem_write;
            illegal   <= d_illegal;
        end else if (flush || out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
